// File: rtl/gpr_file.sv
// gpr_file: 2^ADDR_W x DATA_W register file, r0 hardwired to zero, two combinational
// read ports, one synchronous write port. Optional write-to-read forwarding: GPR_BYPASS_EN.
module gpr_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sin,
  input  logic [ADDR_W-1:0] sa,
  input  logic [ADDR_W-1:0] sb,
  input  logic [ADDR_W-1:0] sc,
  input  logic              sw,
  output logic [DATA_W-1:0] souta,
  output logic [DATA_W-1:0] soutb
);

  localparam int NREG = 2 ** ADDR_W;

  // r0 has no storage; address 0 is decoded to zero on the read side.
  logic [DATA_W-1:0] regs_q [1:NREG-1];
  logic [DATA_W-1:0] regs_d [1:NREG-1];
  logic              wr_en;

  assign wr_en = sw && (sc != '0);

  always_comb begin
    for (int i = 1; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[sc] = sin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = (gi == 0) ? sa : sb;

    always_comb begin
      data = '0;
      if (addr != '0) begin
        data = regs_q[addr];
      end
`ifdef GPR_BYPASS_EN
      // wr_en already excludes address 0, so r0 is never forwarded.
      if (rst_n && wr_en && (addr == sc)) begin
        data = sin;
      end
`endif
    end
  end

  assign souta = g_rd[0].data;
  assign soutb = g_rd[1].data;

endmodule

// File: tb/tb_gpr_file.sv
// Directed self-checking bench for gpr_file; expectations are hand-computed constants.
module tb_gpr_file;

  logic        clk;
  logic        rst_n;
  logic [31:0] sin;
  logic [4:0]  sa;
  logic [4:0]  sb;
  logic [4:0]  sc;
  logic        sw;
  logic [31:0] souta;
  logic [31:0] soutb;

  int total = 0;
  int bad   = 0;

  gpr_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sin   (sin),
    .sa    (sa),
    .sb    (sb),
    .sc    (sc),
    .sw    (sw),
    .souta (souta),
    .soutb (soutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s sa=%0d sb=%0d observed=%h expected=%h", tag, sa, sb, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] bypass_exp;
    rst_n = 1'b1; sw = 1'b0; sc = '0; sin = '0; sa = '0; sb = '0;
    #2;
    check("pre_reset_r0_a", souta, 32'h0);
    check("pre_reset_r0_b", soutb, 32'h0);

    // Reset for one edge, then sweep all addresses on both ports
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sa = 5'(i);
      sb = 5'(31 - i);
      #1;
      check("reset_sweep_a", souta, 32'h0);
      check("reset_sweep_b", soutb, 32'h0);
    end

    // Write r5
    sin = 32'hAAAA_AAAA; sc = 5'd5; sw = 1'b1;
    tick();
    sw = 1'b0; sa = 5'd5; sb = 5'd0;
    #1;
    check("wr_r5_a", souta, 32'hAAAA_AAAA);
    check("wr_r5_b_r0", soutb, 32'h0);

    // Write to r0 is ignored
    sin = 32'hFFFF_FFFF; sc = 5'd0; sw = 1'b1;
    tick();
    sw = 1'b0; sa = 5'd0; sb = 5'd5;
    #1;
    check("wr_r0_a", souta, 32'h0);
    check("wr_r0_b_r5", soutb, 32'hAAAA_AAAA);

    // Second register
    sin = 32'h5555_5555; sc = 5'd10; sw = 1'b1;
    tick();
    sw = 1'b0; sa = 5'd10; sb = 5'd5;
    #1;
    check("wr_r10_a", souta, 32'h5555_5555);
    check("wr_r10_b_r5", soutb, 32'hAAAA_AAAA);
    sa = 5'd10; sb = 5'd10;
    #1;
    check("same_reg_a", souta, 32'h5555_5555);
    check("same_reg_b", soutb, 32'h5555_5555);
    sa = 5'd9; sb = 5'd11;
    #1;
    check("neighbor_r9", souta, 32'h0);
    check("neighbor_r11", soutb, 32'h0);

    // Disabled write leaves r10 alone
    sw = 1'b0; sc = 5'd10; sin = 32'h1234_5678;
    tick();
    sa = 5'd10;
    #1;
    check("sw0_r10", souta, 32'h5555_5555);

    // Reset wins over a same-cycle write
    rst_n = 1'b0; sw = 1'b1; sc = 5'd10; sin = 32'h1234_5678;
    tick();
    rst_n = 1'b1; sw = 1'b0; sa = 5'd10; sb = 5'd5;
    #1;
    check("rst_prio_r10", souta, 32'h0);
    check("rst_clr_r5", soutb, 32'h0);

    // Forwarding window; this is also the first edge after reset deassertion
`ifdef GPR_BYPASS_EN
    bypass_exp = 32'hDEAD_BEEF;
`else
    bypass_exp = 32'h0;
`endif
    sw = 1'b1; sc = 5'd7; sin = 32'hDEAD_BEEF; sa = 5'd7; sb = 5'd7;
    #1;
    check("bypass_pre_a", souta, bypass_exp);
    check("bypass_pre_b", soutb, bypass_exp);
    sb = 5'd6;
    #1;
    check("bypass_other_b", soutb, 32'h0);
    sb = 5'd7;
    tick();
    sw = 1'b0;
    #1;
    check("post_edge_a", souta, 32'hDEAD_BEEF);
    check("post_edge_b", soutb, 32'hDEAD_BEEF);
    sa = 5'd6; sb = 5'd8;
    #1;
    check("nontarget_r6", souta, 32'h0);
    check("nontarget_r8", soutb, 32'h0);

    // Address-0 write never forwards, even with matching read address
    sw = 1'b1; sc = 5'd0; sin = 32'hCAFE_F00D; sa = 5'd0; sb = 5'd7;
    #1;
    check("no_fwd_r0", souta, 32'h0);
    check("r7_hold", soutb, 32'hDEAD_BEEF);
    tick();
    sw = 1'b0;
    #1;
    check("r0_after", souta, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
